// File: rtl/delay_calc_array_if.sv
// Request/result bundle for delay_calc_array.
//   master : drives start, mode, x0, pitch, x_f, z_f, scale, out_ready
//   slave  : drives busy, out_valid, out_ch, out_delay, out_sat, done, state_dbg
// Handshake: a result transfers on a rising clk edge where out_valid and
// out_ready are both 1. While out_valid is 1 the producer holds out_ch,
// out_delay and out_sat stable and does not drop out_valid until that
// transfer. out_ready may change freely and never depends on out_valid.
interface delay_calc_array_if #(
  parameter int CH_W    = 3,
  parameter int COORD_W = 16,
  parameter int SCALE_W = 16,
  parameter int DELAY_W = 12
);
  logic               start;
  logic               mode;
  logic [COORD_W-1:0] x0;
  logic [COORD_W-1:0] pitch;
  logic [COORD_W-1:0] x_f;
  logic [COORD_W-1:0] z_f;
  logic [SCALE_W-1:0] scale;
  logic               busy;
  logic               out_valid;
  logic               out_ready;
  logic [CH_W-1:0]    out_ch;
  logic [DELAY_W-1:0] out_delay;
  logic               out_sat;
  logic               done;
  logic [2:0]         state_dbg;

  modport master (
    output start, mode, x0, pitch, x_f, z_f, scale, out_ready,
    input  busy, out_valid, out_ch, out_delay, out_sat, done, state_dbg
  );

  modport slave (
    input  start, mode, x0, pitch, x_f, z_f, scale, out_ready,
    output busy, out_valid, out_ch, out_delay, out_sat, done, state_dbg
  );
endinterface

// File: rtl/delay_calc_array.sv
// Multi-channel focal delay calculator.
// For one focal point (x_f, z_f) it walks N_CH linearly spaced elements
// (x0, x0+pitch, ...) and for each one computes
//   delay = floor(path * scale / 2^SCALE_FRAC),  path = floor(sqrt(dx^2+dz^2))
//   (+ z_f in plane-wave mode, clamped at 0), saturated to DELAY_W bits.
// Ports:
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : delay_calc_array_if slave (request inputs, result stream,
//                busy/done status, state_dbg = current FSM state encoding)
module delay_calc_array #(
  parameter int N_CH       = 8,
  parameter int CH_W       = 3,
  parameter int COORD_W    = 16,
  parameter int SCALE_W    = 16,
  parameter int SCALE_FRAC = 8,
  parameter int DELAY_W    = 12
) (
  input  logic clk,
  input  logic reset,
  delay_calc_array_if.slave bus
);
  localparam int RT_W   = COORD_W + 2;
  localparam int SQ_W   = 2 * COORD_W + 2;
  localparam int SUM_W  = 2 * RT_W;
  localparam int PATH_W = RT_W + 1;
  localparam int PROD_W = PATH_W + SCALE_W;
  localparam int CNT_W  = $clog2(RT_W + 1);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(N_CH - 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(RT_W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SUB, S_SQUARE, S_SUM, S_SQRT, S_SCALE, S_OUT, S_DONE
  } state_t;

  state_t             state;
  logic               mode_q;
  logic [COORD_W-1:0] xf_q, zf_q, pitch_q, x_elem;
  logic [SCALE_W-1:0] scale_q;
  logic [CH_W-1:0]    ch;
  logic [COORD_W:0]   adx, adz;
  logic [SQ_W-1:0]    dx2, dz2;
  logic [SUM_W-1:0]   rad;
  logic [RT_W-1:0]    rem;
  logic [RT_W-1:0]    root;
  logic [CNT_W-1:0]   bit_cnt;
  logic               busy_q, valid_q, sat_q, done_q;
  logic [CH_W-1:0]    och_q;
  logic [DELAY_W-1:0] delay_q;

  // Differences sign-extended by one bit so the full coordinate span fits.
  logic [COORD_W:0] dx_full, dz_full, dx_abs, dz_abs;
  assign dx_full = {x_elem[COORD_W-1], x_elem} - {xf_q[COORD_W-1], xf_q};
  assign dz_full = {zf_q[COORD_W-1], zf_q};
  assign dx_abs  = dx_full[COORD_W] ? -dx_full : dx_full;
  assign dz_abs  = dz_full[COORD_W] ? -dz_full : dz_full;

  // Restoring square root, two radicand bits per step. Before the last step
  // the partial remainder stays below 2^RT_W; the final remainder is unused,
  // so truncating it to RT_W bits is harmless.
  logic [RT_W+1:0] rem_shift, trial;
  logic            take;
  assign rem_shift = {rem, rad[SUM_W-1 -: 2]};
  assign trial     = {root, 2'b01};
  assign take      = (rem_shift >= trial);

  // Path with optional plane-wave term; bit RT_W+1 is the sign.
  logic [RT_W+1:0]   path_s;
  logic [PATH_W-1:0] path_u;
  logic [PROD_W-1:0] prod, delay_full;
  logic              sat;
  assign path_s     = {2'b00, root} +
                      (mode_q ? {{(RT_W+2-COORD_W){zf_q[COORD_W-1]}}, zf_q} : '0);
  assign path_u     = path_s[RT_W+1] ? '0 : path_s[PATH_W-1:0];
  assign prod       = PROD_W'(path_u) * PROD_W'(scale_q);
  assign delay_full = prod >> SCALE_FRAC;
  assign sat        = |delay_full[PROD_W-1:DELAY_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      mode_q  <= 1'b0;
      xf_q    <= '0;
      zf_q    <= '0;
      pitch_q <= '0;
      x_elem  <= '0;
      scale_q <= '0;
      ch      <= '0;
      adx     <= '0;
      adz     <= '0;
      dx2     <= '0;
      dz2     <= '0;
      rad     <= '0;
      rem     <= '0;
      root    <= '0;
      bit_cnt <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      sat_q   <= 1'b0;
      done_q  <= 1'b0;
      och_q   <= '0;
      delay_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            mode_q  <= bus.mode;
            xf_q    <= bus.x_f;
            zf_q    <= bus.z_f;
            scale_q <= bus.scale;
            pitch_q <= bus.pitch;
            x_elem  <= bus.x0;
            ch      <= '0;
            busy_q  <= 1'b1;
            state   <= S_SUB;
          end
        end
        S_SUB: begin
          adx   <= dx_abs;
          adz   <= dz_abs;
          state <= S_SQUARE;
        end
        S_SQUARE: begin
          dx2   <= SQ_W'(adx) * SQ_W'(adx);
          dz2   <= SQ_W'(adz) * SQ_W'(adz);
          state <= S_SUM;
        end
        S_SUM: begin
          rad     <= SUM_W'(dx2) + SUM_W'(dz2);
          rem     <= '0;
          root    <= '0;
          bit_cnt <= '0;
          state   <= S_SQRT;
        end
        S_SQRT: begin
          rem     <= take ? RT_W'(rem_shift - trial) : RT_W'(rem_shift);
          root    <= {root[RT_W-2:0], take};
          rad     <= rad << 2;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) state <= S_SCALE;
        end
        S_SCALE: begin
          delay_q <= sat ? '1 : delay_full[DELAY_W-1:0];
          sat_q   <= sat;
          och_q   <= ch;
          valid_q <= 1'b1;
          state   <= S_OUT;
        end
        S_OUT: begin
          if (bus.out_ready) begin
            valid_q <= 1'b0;
            x_elem  <= x_elem + pitch_q;
            ch      <= ch + 1'b1;
            if (ch < LAST_CH) begin
              state <= S_SUB;
            end else begin
              done_q <= 1'b1;
              state  <= S_DONE;
            end
          end
        end
        S_DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.out_valid = valid_q;
  assign bus.out_ch    = och_q;
  assign bus.out_delay = delay_q;
  assign bus.out_sat   = sat_q;
  assign bus.done      = done_q;
  assign bus.state_dbg = state;
endmodule

// File: doc/delay_calc_array.md
Name: delay_calc_array

Overview:
- Parametrised, multi-channel successor to the single-element focal delay calculator.
- For one focal point (x_f, z_f), sequentially computes the receive delay of N_CH linearly spaced array elements in sample units. Supports an optional plane-wave transmit term.
- Contains its own bit-serial integer square root, so no external sqrt instance is needed.
- Streams per-channel results to the beamformer delay RAM over a valid/ready handshake.

Parameters:
- N_CH, 8: number of array elements (channels) processed per request.
- CH_W, 3: channel index width. Must satisfy 2^CH_W >= N_CH.
- COORD_W, 16: width of coordinates and pitch (signed two's complement, grid units).
- SCALE_W, 16: width of the unsigned distance-to-samples scale factor.
- SCALE_FRAC, 8: fractional bits of the scale factor.
- DELAY_W, 12: output delay width, in samples.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request pulse; honoured only in IDLE.
- mode  in  1  0 = receive path only; 1 = plane-wave transmit (z_f) plus receive path.
- x0  in  COORD_W  signed x position of element 0.
- pitch  in  COORD_W  signed element spacing.
- x_f  in  COORD_W  signed focal x.
- z_f  in  COORD_W  signed focal z.
- scale  in  SCALE_W  unsigned samples-per-grid-unit, Q(SCALE_W-SCALE_FRAC).SCALE_FRAC.
- busy  out  1  high whenever state != IDLE.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- out_ch  out  CH_W  channel index of the current result.
- out_delay  out  DELAY_W  delay in samples.
- out_sat  out  1  out_delay was saturated.
- done  out  1  one-cycle pulse after the last channel is accepted.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal registers 0. Reset mid-operation aborts immediately: no done pulse and no further out_valid.
- Input latching:
  - When start=1 in IDLE, the block latches mode, x_f, z_f, scale and pitch.
  - It also loads x_elem = x0 and ch = 0.
  - All later input changes are ignored until the next request.
  - start while busy is ignored.
- States: IDLE -> SUB -> SQUARE -> SUM -> SQRT -> SCALE -> OUT -> (SUB for the next channel | DONE) -> IDLE.
- SUB: dx = x_elem - x_f and dz = z_f, both sign-extended to COORD_W+1 bits. Store |dx| and |dz| as COORD_W+1-bit unsigned values.
- SQUARE: dx2 = |dx|^2 and dz2 = |dz|^2, each 2*COORD_W+2 bits.
- SUM: sum = dx2 + dz2, 2*COORD_W+4 bits.
- SQRT:
  - Non-restoring or restoring bit-serial integer square root, one result bit per cycle, exactly RT_W = COORD_W+2 cycles.
  - root = floor(sqrt(sum)), RT_W bits.
- SCALE:
  - path = root when mode=0.
  - path = root + z_f when mode=1; a negative result is clamped to 0.
  - delay = (path * scale) >> SCALE_FRAC, computed at full width.
  - If delay > 2^DELAY_W-1: out_delay = all ones and out_sat = 1. Otherwise out_sat = 0.
- OUT:
  - out_valid = 1. out_ch, out_delay and out_sat are held stable until a cycle with out_valid & out_ready.
  - On that handshake: x_elem += pitch (COORD_W-bit wrap; out-of-range elements are illegal and unchecked) and ch += 1.
  - Then go to SUB if ch < N_CH-1, else to DONE.
  - out_valid deasserts the cycle after the handshake.
- DONE: done = 1 for exactly one cycle, then IDLE; busy falls that same cycle.
- Latency:
  - start accepted in cycle T gives first out_valid in cycle T+5+RT_W (T+23 at defaults).
  - Each subsequent channel has out_valid exactly RT_W+5 cycles after the previous handshake, assuming no backpressure.

Test Plan:
- Constant geometry: x0=0, pitch=0, x_f=3, z_f=4, mode=0, scale=256, out_ready=1 -> 8 results with out_ch 0..7, out_delay=5, out_sat=0; done one cycle after the ch7 handshake.
- Signed spread: x0=-4, pitch=2, x_f=0, z_f=3, scale=256.
  - mode=0 -> ch0..4 delays 5,3,3,3,5.
  - Rerun with mode=1 -> 8,6,6,6,8.
- Saturation: x0=-32768, x_f=32767, z_f=0, pitch=0, scale=65535 -> out_delay=4095 and out_sat=1 on every channel.
- Backpressure: out_ready held low 10 cycles while ch2 is valid -> out_valid, out_ch=2 and out_delay stay stable; ch3 appears only after acceptance plus RT_W+5 cycles.
- Latency and ignore: start in cycle T, out_ready=1 -> first out_valid at T+23. A second start at T+5 has no effect.
- Reset mid-SQRT -> out_valid=0, busy=0 and done=0 next cycle. A fresh request then produces correct results from ch0.
